apb_regfile_slave: RTL and testbench
====================================

APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 32; number of 8-bit storage registers at PADDR[7:0] = 0x00..DEPTH-1, where DEPTH is at most 254.
REQ-002 SHALL have parameter RST_WAIT, default 0; reset value of the wait-state field, range 0..7.
REQ-003 PCLK  in  1  single clock, all state updates on rising edge.
REQ-004 PRESETn  in  1  reset, synchronous, active-low.
REQ-005 PSEL  in  1  select from the master decoder.
REQ-006 PENABLE  in  1  access-phase qualifier.
REQ-007 PWRITE  in  1  1 = write, 0 = read.
REQ-008 PADDR  in  9  address; bit 8 ignored, because slave decode is done upstream.
REQ-009 PWDATA  in  8  write data.
REQ-010 PRDATA  out  8  read data, valid only while PREADY=1 on a read.
REQ-011 PREADY  out  1  transfer completion.
REQ-012 PSLVERR  out  1  error response, valid only while PREADY=1.

Function
REQ-013 SHALL implement the FSM states IDLE and ACCESS.
REQ-014 In IDLE, on an edge with PSEL=1 and PENABLE=0 (setup), SHALL latch PADDR[7:0], PWRITE and PWDATA, load wait counter from CFG[2:0], and go to ACCESS.
REQ-015 In IDLE, PSEL=1 with PENABLE=1 (no prior setup) SHALL be ignored, with no state change and PREADY=0.
REQ-016 In ACCESS, PREADY SHALL be 1 when wait counter = 0, else 0; the counter SHALL decrement by 1 on each edge where it is nonzero and PSEL=PENABLE=1.
REQ-017 SHALL give N wait cycles for CFG[2:0]=N, so the access phase is N+1 cycles (0 waits gives a 2-cycle transfer).
REQ-018 On the edge where PREADY=1 and PSEL=PENABLE=1, SHALL commit the write if it is legal and return to IDLE; a back-to-back setup in the following cycle SHALL be accepted from IDLE.
REQ-019 In ACCESS, if PSEL drops, SHALL return to IDLE with no write, no counter update, and PREADY/PSLVERR=0.
REQ-020 Address map: 0x00..DEPTH-1 is the R/W regfile; 0xFE is XCNT (RO); 0xFF is CFG (R/W, bits[2:0]=wait count, bits[7:3] read 0, writes ignored); all other addresses are unmapped.
REQ-021 An access to an unmapped address, or a write to XCNT, SHALL complete with PSLVERR=1 and PRDATA=0x00, and SHALL modify no state.
REQ-022 XCNT SHALL increment by 1 (8-bit, wrapping 0xFF->0x00) on every completed transfer with PSLVERR=0.
REQ-023 PRDATA SHALL be 0x00 whenever PREADY=0 or PWRITE(latched)=1.
REQ-024 PREADY and PSLVERR SHALL be 0 in IDLE.
REQ-025 PRDATA on a read of CFG SHALL reflect its value before any write committing in the same cycle.

Reset
REQ-026 On an edge with PRESETn=0: FSM goes to IDLE, wait counter=0, XCNT=0x00, CFG[2:0]=RST_WAIT, all regfile entries=0x00, PRDATA=0x00, PREADY=0, PSLVERR=0.
REQ-027 Reset asserted during ACCESS SHALL abort the transfer with no write, and SHALL take priority over any completion in the same edge.

Structure
REQ-028 The shared package/include apb_defs SHALL hold ADDR_W=9, DATA_W=8, ADDR_XCNT=0xFE, ADDR_CFG=0xFF and the state encodings IDLE/ACCESS; master and slave use the same file.
REQ-029 SHALL instantiate one sub-module, apb_regfile (DEPTH x 8, synchronous write, combinational read, synchronous reset clear); the FSM, wait counter, decode, CFG and XCNT stay in apb_regfile_slave.

Verification
REQ-030 Reset, then write 0xA5 to 0x03, then read 0x03 -> PREADY in the 2nd cycle of each transfer, PRDATA=0xA5, PSLVERR=0, XCNT=0x02.
REQ-031 Write 0x03 to 0xFF, then read 0x10 -> exactly 3 access cycles with PREADY=0 before PREADY=1, PRDATA=0x00; reading 0xFF returns 0x03.
REQ-032 Write 0x5A to 0x40 and write to 0xFE -> PSLVERR=1 on completion, regfile and XCNT unchanged, following read of 0x40 gives PSLVERR=1 and PRDATA=0x00.
REQ-033 With CFG=5, drop PSEL in the 2nd wait cycle of a write of 0x77 to 0x01 -> FSM returns to IDLE, 0x01 keeps its old value, XCNT unchanged.
REQ-034 Assert PRESETn=0 for 1 cycle mid-wait -> all outputs 0 next cycle, CFG=RST_WAIT, XCNT=0x00; then perform 256 good transfers -> XCNT wraps to 0x00.
REQ-035 Run back-to-back writes to 0x00..0x1F with no idle cycles, then read them back -> all 32 transfers accepted and the data matches.

Source files
------------

// File: rtl/apb_defs.sv
// Shared APB definitions used by both the master and the slave side.
// Bus widths, special register addresses and the slave FSM encodings.
package apb_defs;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    localparam logic [7:0] ADDR_XCNT = 8'hFE;
    localparam logic [7:0] ADDR_CFG  = 8'hFF;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;
endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W storage array: synchronous write, combinational read,
// synchronous clear. Out-of-range addresses read as zero and never write.
module apb_regfile
    import apb_defs::*;
#(
    parameter int DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [7:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_L = 8'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr < DEPTH_L)) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    assign rdata = (raddr < DEPTH_L) ? mem[raddr[IDX_W-1:0]] : '0;
endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave with a byte register file, a wait-state CFG register and a
// read-only count (XCNT) of transfers that completed without error.
module apb_regfile_slave
    import apb_defs::*;
#(
    parameter int DEPTH    = 32,
    parameter int RST_WAIT = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [0:0]        dbg_state
);
    localparam logic [7:0] DEPTH_L = 8'(DEPTH);

    // Handshake: a setup cycle (PSEL=1, PENABLE=0) seen in IDLE opens a transfer;
    // it completes on the edge where PSEL=PENABLE=PREADY=1. PREADY, PSLVERR and
    // PRDATA are only meaningful in that completing cycle and are zero otherwise.
    logic [0:0]        state;
    logic [7:0]        addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        wait_cnt;
    logic [2:0]        cfg;
    logic [DATA_W-1:0] xcnt;
    logic [DATA_W-1:0] rf_rdata;
    logic [DATA_W-1:0] rd_mux;
    logic              in_rf, is_xcnt, is_cfg, slv_err, ready, complete;
    logic              unused_paddr_msb;

    assign unused_paddr_msb = PADDR[8];

    assign in_rf    = addr_q < DEPTH_L;
    assign is_xcnt  = addr_q == ADDR_XCNT;
    assign is_cfg   = addr_q == ADDR_CFG;
    assign slv_err  = !(in_rf || is_xcnt || is_cfg) || (write_q && is_xcnt);
    assign ready    = (state == ACCESS) && PSEL && (wait_cnt == 3'd0);
    assign complete = ready && PENABLE;

    apb_regfile #(.DEPTH(DEPTH)) u_regfile (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .we    (complete && write_q && in_rf),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdata (rf_rdata)
    );

    // CFG is read from the register itself, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        if (in_rf) begin
            rd_mux = rf_rdata;
        end else if (is_xcnt) begin
            rd_mux = xcnt;
        end else if (is_cfg) begin
            rd_mux = {5'b0, cfg};
        end
    end

    assign PREADY    = ready;
    assign PSLVERR   = ready && slv_err;
    assign PRDATA    = (ready && !write_q && !slv_err) ? rd_mux : '0;
    assign dbg_state = state;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state    <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            cfg      <= 3'(RST_WAIT);
            xcnt     <= '0;
        end else if (state == IDLE) begin
            if (PSEL && !PENABLE) begin
                state    <= ACCESS;
                addr_q   <= PADDR[7:0];
                write_q  <= PWRITE;
                wdata_q  <= PWDATA;
                wait_cnt <= cfg;
            end
        end else begin
            if (!PSEL) begin
                state <= IDLE;
            end else if (PENABLE) begin
                if (wait_cnt == 3'd0) begin
                    state <= IDLE;
                    if (write_q && is_cfg) begin
                        cfg <= wdata_q[2:0];
                    end
                    if (!slv_err) begin
                        xcnt <= xcnt + 8'd1;
                    end
                end else begin
                    wait_cnt <= wait_cnt - 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: the driver pushes the expected
// {PSLVERR, PRDATA} of each transfer, the monitor pops it on completion.
module tb_apb_regfile_slave;
    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       PSEL, PENABLE, PWRITE;
    logic [8:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY, PSLVERR;
    logic [0:0] dbg_state;

    int tests = 0;
    int fails = 0;
    logic [8:0] exp_q[$];

    apb_regfile_slave #(.DEPTH(32), .RST_WAIT(0)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge PCLK) begin
        if (PRESETn && PSEL && PENABLE && PREADY) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL resp: unexpected completion at addr 0x%0h", PADDR);
            end else begin
                chk("resp {err,rdata}", {PSLVERR, PRDATA}, exp_q.pop_front());
            end
        end else if (!PREADY) begin
            chk("idle outputs", {PSLVERR, PRDATA}, 9'h000);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle(input int n);
        PSEL = 1'b0;
        PENABLE = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                        input logic exp_err, input logic [7:0] exp_rd, input int exp_waits);
        int waits;
        exp_q.push_back({exp_err, (wr || exp_err) ? 8'h00 : exp_rd});
        PSEL = 1'b1;
        PENABLE = 1'b0;
        PWRITE = wr;
        PADDR = {1'b0, addr};
        PWDATA = wd;
        tick();
        PENABLE = 1'b1;
        waits = 0;
        while (!PREADY && waits < 20) begin
            tick();
            waits++;
        end
        if (!PREADY) begin
            tests++;
            fails++;
            $display("FAIL timeout: no PREADY for addr 0x%0h after %0d cycles", addr, waits);
            void'(exp_q.pop_back());
            idle(1);
        end else begin
            chk("wait cycles", 9'(waits), 9'(exp_waits));
            tick();
        end
    endtask

    initial begin
        PRESETn = 1'b0;
        PSEL = 1'b0;
        PENABLE = 1'b0;
        PWRITE = 1'b0;
        PADDR = '0;
        PWDATA = '0;
        tick();
        tick();
        chk("reset PREADY", 9'(PREADY), 9'h0);
        chk("reset PSLVERR", 9'(PSLVERR), 9'h0);
        chk("reset PRDATA", 9'(PRDATA), 9'h0);
        chk("reset state", 9'(dbg_state), 9'h0);
        PRESETn = 1'b1;
        tick();

        // access phase without setup is ignored
        PSEL = 1'b1;
        PENABLE = 1'b1;
        tick();
        tick();
        chk("no-setup PREADY", 9'(PREADY), 9'h0);
        chk("no-setup state", 9'(dbg_state), 9'h0);
        idle(1);

        // basic write/read, zero wait states
        xfer(1'b1, 8'h03, 8'hA5, 1'b0, 8'h00, 0);
        xfer(1'b0, 8'h03, 8'h00, 1'b0, 8'hA5, 0);
        xfer(1'b0, 8'hFE, 8'h00, 1'b0, 8'h02, 0);
        idle(1);

        // three wait states via CFG
        xfer(1'b1, 8'hFF, 8'h03, 1'b0, 8'h00, 0);
        xfer(1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 3);
        xfer(1'b0, 8'hFF, 8'h00, 1'b0, 8'h03, 3);
        idle(1);

        // error responses leave state alone
        xfer(1'b1, 8'h40, 8'h5A, 1'b1, 8'h00, 3);
        xfer(1'b1, 8'hFE, 8'h12, 1'b1, 8'h00, 3);
        xfer(1'b0, 8'h40, 8'h00, 1'b1, 8'h00, 3);
        xfer(1'b0, 8'hFE, 8'h00, 1'b0, 8'h06, 3);
        idle(1);

        // CFG upper bits ignored, then a PSEL drop mid-wait aborts the write
        xfer(1'b1, 8'hFF, 8'hFD, 1'b0, 8'h00, 3);
        xfer(1'b0, 8'hFF, 8'h00, 1'b0, 8'h05, 5);
        xfer(1'b1, 8'h01, 8'h11, 1'b0, 8'h00, 5);
        PSEL = 1'b1;
        PENABLE = 1'b0;
        PWRITE = 1'b1;
        PADDR = 9'h001;
        PWDATA = 8'h77;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0;
        #1;
        chk("abort PREADY", 9'(PREADY), 9'h0);
        chk("abort PSLVERR", 9'(PSLVERR), 9'h0);
        tick();
        chk("abort state", 9'(dbg_state), 9'h0);
        idle(1);
        xfer(1'b0, 8'h01, 8'h00, 1'b0, 8'h11, 5);
        xfer(1'b0, 8'hFE, 8'h00, 1'b0, 8'h0B, 5);
        idle(1);

        // reset in the middle of a wait
        PSEL = 1'b1;
        PENABLE = 1'b0;
        PWRITE = 1'b0;
        PADDR = 9'h001;
        tick();
        PENABLE = 1'b1;
        tick();
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
        PSEL = 1'b0;
        PENABLE = 1'b0;
        #1;
        chk("rst-mid PREADY", 9'(PREADY), 9'h0);
        chk("rst-mid PSLVERR", 9'(PSLVERR), 9'h0);
        chk("rst-mid PRDATA", 9'(PRDATA), 9'h0);
        chk("rst-mid state", 9'(dbg_state), 9'h0);
        tick();
        xfer(1'b0, 8'hFE, 8'h00, 1'b0, 8'h00, 0);
        xfer(1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 0);
        xfer(1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 0);
        for (int i = 0; i < 253; i++) begin
            xfer(1'b1, 8'(i % 32), 8'(i), 1'b0, 8'h00, 0);
        end
        xfer(1'b0, 8'hFE, 8'h00, 1'b0, 8'h00, 0);
        idle(1);

        // back-to-back fill and readback
        for (int i = 0; i < 32; i++) begin
            xfer(1'b1, 8'(i), 8'(i * 7 + 3), 1'b0, 8'h00, 0);
        end
        for (int i = 0; i < 32; i++) begin
            xfer(1'b0, 8'(i), 8'h00, 1'b0, 8'(i * 7 + 3), 0);
        end
        idle(3);

        // final report
        chk("scoreboard drained", 9'(exp_q.size()), 9'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
